// File: rtl/doppler_fll.sv
// doppler_fll: frequency-locked loop that steers the LO tuning DAC until the
// IF edge count per gate matches the Doppler set-point (dopset). When the
// tracking qualifiers are not both high, the DAC is swept instead (scan mode).
// Build option: define DOPPLER_SDM_EN to drive pwm from a first-order
// sigma-delta modulator instead of the counter-compare PWM.
module doppler_fll #(
  parameter int CNT_W     = 12,
  parameter int DAC_W     = 10,
  parameter int SCAN_DIV  = 122760,
  parameter int TRACK_DIV = 8,
  parameter int INT_DEPTH = 64,
  parameter int DEADBAND  = 0,
  parameter int LOCK_CNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] dopset,
  input  logic [DAC_W-1:0] dacset,
  input  logic             dacload,
  input  logic             ifin,
  input  logic             codetrack,
  input  logic             doptrack,
  output logic [CNT_W-1:0] iffreq,
  output logic [DAC_W-1:0] dacvalue,
  output logic             gate,
  output logic             locked,
  output logic             pwm
);

  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int GC_W  = (TRACK_DIV > 1) ? $clog2(TRACK_DIV) : 1;
  localparam int INT_W = $clog2(INT_DEPTH) + 1;
  localparam int LK_W  = $clog2(LOCK_CNT + 1);

  localparam logic [PS_W-1:0]          PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [GC_W-1:0]          GC_LAST  = GC_W'(TRACK_DIV - 1);
  localparam logic signed [INT_W-1:0]  INT_MAX  = INT_W'(INT_DEPTH - 1);
  localparam logic signed [INT_W-1:0]  INT_MIN  = -INT_MAX;
  localparam logic signed [INT_W-1:0]  INT_ONE  = INT_W'(1);
  localparam logic signed [CNT_W+1:0]  DB       = (CNT_W + 2)'(DEADBAND);
  localparam logic [LK_W-1:0]          LOCK_MAX = LK_W'(LOCK_CNT);

  typedef enum logic {SCAN = 1'b0, TRACK = 1'b1} mode_t;

  logic [2:0]              ifsync;
  logic                    if_rise;
  logic [PS_W-1:0]         pscnt;
  logic [GC_W-1:0]         gcnt;
  logic                    scan_tick;
  logic                    gate_end;
  logic [CNT_W-1:0]        cnt;
  logic signed [CNT_W+1:0] err;
  logic                    too_fast;
  logic                    too_slow;
  logic                    in_band;
  logic                    track_req;
  mode_t                   mode_q;
  mode_t                   mode_d;
  logic                    mode_chg;
  logic signed [INT_W-1:0] integ;
  logic signed [INT_W-1:0] integ_d;
  logic [DAC_W-1:0]        dac_d;
  logic                    step_up;
  logic                    step_dn;
  logic [LK_W-1:0]         lockrun;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ifsync <= '0;
    else     ifsync <= {ifsync[1:0], ifin};
  end

  assign if_rise   = ifsync[1] & ~ifsync[2];
  assign scan_tick = (pscnt == PS_LAST);
  assign gate_end  = scan_tick && (gcnt == GC_LAST);

  // Scan prescaler and gate counter; gate is registered alongside iffreq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pscnt <= '0;
      gcnt  <= '0;
      gate  <= 1'b0;
    end else begin
      if (scan_tick) begin
        pscnt <= '0;
        gcnt  <= gate_end ? '0 : gcnt + GC_W'(1);
      end else begin
        pscnt <= pscnt + PS_W'(1);
      end
      gate <= gate_end;
    end
  end

  // Saturating IF edge counter; an edge landing on the gate opens the new gate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      iffreq <= '0;
    end else if (gate_end) begin
      iffreq <= cnt;
      cnt    <= if_rise ? CNT_W'(1) : '0;
    end else if (if_rise && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign err      = $signed({2'b00, cnt}) - $signed({2'b00, dopset});
  assign too_fast = (err > DB);
  assign too_slow = (err < -DB);
  assign in_band  = !too_fast && !too_slow;

  assign track_req = codetrack & doptrack;
  assign mode_d    = track_req ? TRACK : SCAN;
  assign mode_chg  = (mode_d != mode_q);

  // Mode register (scan after reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= SCAN;
    else     mode_q <= mode_d;
  end

  // Loop filter next state: dacload beats a mode-change clear, which beats a step.
  always_comb begin
    integ_d = integ;
    dac_d   = dacvalue;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (mode_q == SCAN) begin
      step_up = scan_tick;
    end else if (gate_end) begin
      step_up = too_slow;
      step_dn = too_fast;
    end
    if (dacload) begin
      dac_d   = dacset;
      integ_d = '0;
    end else if (mode_chg) begin
      integ_d = '0;
    end else if (step_up) begin
      if (integ == INT_MAX) begin
        integ_d = '0;
        if (mode_q == SCAN)       dac_d = dacvalue + DAC_W'(1);
        else if (dacvalue != '1)  dac_d = dacvalue + DAC_W'(1);
      end else begin
        integ_d = integ + INT_ONE;
      end
    end else if (step_dn) begin
      if (integ == INT_MIN) begin
        integ_d = '0;
        if (dacvalue != '0) dac_d = dacvalue - DAC_W'(1);
      end else begin
        integ_d = integ - INT_ONE;
      end
    end
  end

  // Integrator and DAC word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ    <= '0;
      dacvalue <= '0;
    end else begin
      integ    <= integ_d;
      dacvalue <= dac_d;
    end
  end

  // Lock detector: run of in-band track gates; locked trails the run by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockrun <= '0;
      locked  <= 1'b0;
    end else begin
      if (!track_req || (mode_q == SCAN) || dacload) begin
        lockrun <= '0;
      end else if (gate_end) begin
        if (!in_band)                lockrun <= '0;
        else if (lockrun != LOCK_MAX) lockrun <= lockrun + LK_W'(1);
      end
      locked <= track_req && !dacload && (lockrun == LOCK_MAX);
    end
  end

`ifdef DOPPLER_SDM_EN
  logic [DAC_W-1:0] sdacc;
  logic [DAC_W:0]   sdsum;

  assign sdsum = {1'b0, sdacc} + {1'b0, dacvalue};

  // First-order sigma-delta: the accumulator carry is the output bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdacc <= '0;
      pwm   <= 1'b0;
    end else begin
      sdacc <= sdsum[DAC_W-1:0];
      pwm   <= sdsum[DAC_W];
    end
  end
`else
  logic [DAC_W-1:0] pwmcnt;
  logic [DAC_W-1:0] duty;

  // Counter-compare PWM; duty is shadowed at period end so a period never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwmcnt <= '0;
      duty   <= '0;
      pwm    <= 1'b0;
    end else begin
      pwmcnt <= pwmcnt + DAC_W'(1);
      if (pwmcnt == '1) duty <= dacvalue;
      pwm <= (pwmcnt < duty);
    end
  end
`endif

endmodule

// File: tb/tb_doppler_fll.sv
// Self-checking bench for doppler_fll with a cycle-level reference model of
// the loop behaviour, plus directed literal checks for each test scenario.
module tb_doppler_fll;

  localparam int CNT_W     = 8;
  localparam int DAC_W     = 6;
  localparam int SCAN_DIV  = 10;
  localparam int TRACK_DIV = 4;
  localparam int INT_DEPTH = 4;
  localparam int DEADBAND  = 1;
  localparam int LOCK_CNT  = 3;
  localparam int GATE_LEN  = SCAN_DIV * TRACK_DIV;
  localparam int DACMAX    = (1 << DAC_W) - 1;
  localparam int CNTMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] dopset = '0;
  logic [DAC_W-1:0] dacset = '0;
  logic             dacload = 1'b0;
  logic             ifin = 1'b0;
  logic             codetrack = 1'b0;
  logic             doptrack = 1'b0;
  logic [CNT_W-1:0] iffreq, iffreq2;
  logic [DAC_W-1:0] dacvalue, dacvalue2;
  logic             gate, gate2, locked, locked2, pwm, pwm2;

  int errors = 0;
  int checks = 0;
  int npulse = 0;
  int bcyc = 0;

  always #5 clk = ~clk;

  doppler_fll #(
    .CNT_W(CNT_W), .DAC_W(DAC_W), .SCAN_DIV(SCAN_DIV), .TRACK_DIV(TRACK_DIV),
    .INT_DEPTH(INT_DEPTH), .DEADBAND(DEADBAND), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .rst(rst), .dopset(dopset), .dacset(dacset), .dacload(dacload),
    .ifin(ifin), .codetrack(codetrack), .doptrack(doptrack), .iffreq(iffreq),
    .dacvalue(dacvalue), .gate(gate), .locked(locked), .pwm(pwm)
  );

  // Long-gate instance: 800-cycle gate lets the edge counter reach saturation.
  doppler_fll #(
    .CNT_W(CNT_W), .DAC_W(DAC_W), .SCAN_DIV(200), .TRACK_DIV(TRACK_DIV),
    .INT_DEPTH(INT_DEPTH), .DEADBAND(DEADBAND), .LOCK_CNT(LOCK_CNT)
  ) dut2 (
    .clk(clk), .rst(rst), .dopset(dopset), .dacset(dacset), .dacload(dacload),
    .ifin(ifin), .codetrack(codetrack), .doptrack(doptrack), .iffreq(iffreq2),
    .dacvalue(dacvalue2), .gate(gate2), .locked(locked2), .pwm(pwm2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // IF stimulus: npulse one-cycle pulses at the start of every 40-cycle window,
  // so any 40 consecutive cycles hold exactly npulse rising edges.
  initial begin
    forever begin
      @(negedge clk);
      bcyc++;
      ifin = (npulse > 0) && ((bcyc % GATE_LEN) < 2 * npulse) && ((bcyc % 2) == 0);
    end
  end

  // Reference model: counts cycles since reset, derives ticks/gates from them.
  int m_cyc, m_cnt, m_iffreq, m_dac, m_integ, m_lockrun, m_e, m_step;
  bit m_mode, m_gate, m_locked, m_p1, m_p2, m_p3, m_trk, m_edge, m_tick, m_gt, m_newlk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_cnt = 0; m_iffreq = 0; m_dac = 0; m_integ = 0; m_lockrun = 0;
      m_mode = 0; m_gate = 0; m_locked = 0; m_p1 = 0; m_p2 = 0; m_p3 = 0;
    end else begin
      m_cyc++;
      m_trk  = codetrack && doptrack;
      m_edge = m_p2 && !m_p3;
      m_p3 = m_p2; m_p2 = m_p1; m_p1 = ifin;
      m_tick = (m_cyc % SCAN_DIV) == 0;
      m_gt   = (m_cyc % GATE_LEN) == 0;
      m_e    = m_cnt - int'(dopset);
      m_gate = m_gt;
      if (m_gt) begin
        m_iffreq = m_cnt;
        m_cnt = m_edge ? 1 : 0;
      end else if (m_edge && m_cnt < CNTMAX) begin
        m_cnt++;
      end
      m_newlk = m_trk && !dacload && (m_lockrun >= LOCK_CNT);
      if (!m_trk || !m_mode || dacload) m_lockrun = 0;
      else if (m_gt) m_lockrun = (m_e >= -DEADBAND && m_e <= DEADBAND) ? m_lockrun + 1 : 0;
      m_locked = m_newlk;
      if (dacload) begin
        m_dac = int'(dacset);
        m_integ = 0;
      end else if (m_trk != m_mode) begin
        m_integ = 0;
      end else begin
        m_step = 0;
        if (!m_mode && m_tick) m_step = 1;
        else if (m_mode && m_gt) m_step = (m_e > DEADBAND) ? -1 : ((m_e < -DEADBAND) ? 1 : 0);
        m_integ += m_step;
        if (m_integ >= INT_DEPTH) begin
          m_integ = 0;
          m_dac = m_mode ? ((m_dac < DACMAX) ? m_dac + 1 : DACMAX) : ((m_dac + 1) % (DACMAX + 1));
        end else if (m_integ <= -INT_DEPTH) begin
          m_integ = 0;
          m_dac = (m_dac > 0) ? m_dac - 1 : 0;
        end
      end
      m_mode = m_trk;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("iffreq", int'(iffreq), m_iffreq);
      chk("dacvalue", int'(dacvalue), m_dac);
      chk("gate", int'(gate), int'(m_gate));
      chk("locked", int'(locked), int'(m_locked));
    end
  end

  task automatic wait_gate(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gate && n < 200);
    if (!gate) chk("gate_timeout", int'(gate), 1);
  endtask

  task automatic wait_gate2(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gate2 && n < 1000);
    if (!gate2) chk("gate2_timeout", int'(gate2), 1);
  endtask

  task automatic pwm_window(input int dac, input int expect_hi);
    int hi;
    dacload = 1'b1;
    dacset  = DAC_W'(dac);
    @(negedge clk);
    dacload = 1'b0;
    repeat (130) @(negedge clk);
    hi = 0;
    repeat (64) begin
      @(negedge clk);
      hi += int'(pwm);
    end
    chk("pwm_high_count", hi, expect_hi);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_iffreq", int'(iffreq), 0);
    chk("rst_dacvalue", int'(dacvalue), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_dut2", int'({iffreq2, dacvalue2, gate2, locked2, pwm2}), 0);

    // 1: scan sweep from preset 62, wrap through 0.
    rst = 1'b0; dacload = 1'b1; dacset = 6'd62;
    @(negedge clk);
    dacload = 1'b0;
    n = 1;
    while (!gate && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_gate_cycles", n, 40);
    chk("scan_dac_g1", int'(dacvalue), 63);
    for (int g = 0; g < 7; g++) begin
      wait_gate(n);
      chk("scan_gate_period", n, 40);
      chk("scan_dac", int'(dacvalue), g);
    end

    // 2: track, 10 edges vs set-point 20 -> DAC climbs once per 4 gates, saturates.
    codetrack = 1'b1; doptrack = 1'b1; dopset = 8'd20; npulse = 10;
    dacload = 1'b1; dacset = 6'd61;
    @(negedge clk);
    dacload = 1'b0;
    for (int g = 1; g <= 12; g++) begin
      wait_gate(n);
      if (g == 1)  chk("trk_dac_g1", int'(dacvalue), 61);
      if (g == 2)  chk("trk_iffreq_10", int'(iffreq), 10);
      if (g == 4)  chk("trk_dac_g4", int'(dacvalue), 62);
      if (g == 8)  chk("trk_dac_g8", int'(dacvalue), 63);
      if (g == 12) chk("trk_dac_sat", int'(dacvalue), 63);
    end

    // 3: on-frequency -> no step, lock after 3 gates, dropped qualifier unlocks.
    npulse = 20; dopset = 8'd20;
    wait_gate(n);
    dacload = 1'b1; dacset = 6'd30;
    @(negedge clk);
    dacload = 1'b0;
    wait_gate(n);
    chk("lock_iffreq_20", int'(iffreq), 20);
    chk("lock_dac_hold", int'(dacvalue), 30);
    wait_gate(n);
    wait_gate(n);
    chk("lock_not_yet", int'(locked), 0);
    chk("lock_dac_hold3", int'(dacvalue), 30);
    @(negedge clk);
    chk("lock_set", int'(locked), 1);
    codetrack = 1'b0;
    @(negedge clk);
    chk("lock_drop", int'(locked), 0);

    // 4: deadband edges (9, 11 around 10) hold; 12 steps the DAC down.
    codetrack = 1'b1; dopset = 8'd10; npulse = 9;
    wait_gate(n);
    dacload = 1'b1; dacset = 6'd40;
    @(negedge clk);
    dacload = 1'b0;
    wait_gate(n);
    chk("db_iffreq_9", int'(iffreq), 9);
    chk("db_dac_9", int'(dacvalue), 40);
    wait_gate(n);
    wait_gate(n);
    @(negedge clk);
    chk("db_locked_9", int'(locked), 1);
    npulse = 11;
    wait_gate(n);
    wait_gate(n);
    chk("db_iffreq_11", int'(iffreq), 11);
    chk("db_dac_11", int'(dacvalue), 40);
    npulse = 12;
    wait_gate(n);
    dacload = 1'b1; dacset = 6'd40;
    @(negedge clk);
    dacload = 1'b0;
    wait_gate(n);
    chk("db_iffreq_12", int'(iffreq), 12);
    wait_gate(n);
    chk("db_unlocked_12", int'(locked), 0);
    wait_gate(n);
    wait_gate(n);
    chk("db_dac_39", int'(dacvalue), 39);
    repeat (4) wait_gate(n);
    chk("db_dac_38", int'(dacvalue), 38);

    // 5: counter saturation on the long-gate instance, then reset mid-gate.
    npulse = 20;
    wait_gate2(n);
    wait_gate2(n);
    chk("sat_iffreq2", int'(iffreq2), 255);
    wait_gate(n);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_iffreq", int'(iffreq), 0);
    chk("midrst_dacvalue", int'(dacvalue), 0);
    chk("midrst_gate", int'(gate), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_pwm", int'(pwm), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gate && n < 100);
    chk("post_rst_gate_cycles", n, 40);

    // 6: PWM duty over a 64-cycle window with the DAC held on-frequency.
    dopset = 8'd20;
    pwm_window(16, 16);
    pwm_window(0, 0);
    pwm_window(63, 63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
